// File: rtl/locn_tx_packer_pkg.sv
// locn_pkg: shared types and constants for the location result packer.
// Build option: define LOCN_PKT_DMIN_EN to append the Dmin word to each frame.
package locn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DRAIN
  } locn_state_e;

  typedef logic [31:0] locn_word_t;

  localparam logic [7:0] LOCN_HDR_DEFAULT    = 8'hA5;
  localparam int         LOCN_FRAME_LEN_BASE = 10;  // hdr + X + Y + chk
  localparam int         LOCN_FRAME_LEN_DMIN = 14;  // hdr + X + Y + Dmin + chk

`ifdef LOCN_PKT_DMIN_EN
  localparam int LOCN_FRAME_LEN = LOCN_FRAME_LEN_DMIN;
  typedef struct packed {
    locn_word_t x;
    locn_word_t y;
    locn_word_t dmin;
  } locn_result_t;
`else
  localparam int LOCN_FRAME_LEN = LOCN_FRAME_LEN_BASE;
  typedef struct packed {
    locn_word_t x;
    locn_word_t y;
  } locn_result_t;
`endif

  // Byte k of a word, k=0 is the most significant byte (wire order).
  function automatic logic [7:0] word_byte(input locn_word_t w, input logic [1:0] k);
    locn_word_t s;
    s = w << {k, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/locn_tx_packer_if.sv
// locn_tx_packer_if: solver-side result strobe/data and host-side UART status.
// master = solver/host environment, slave = the packer.
interface locn_tx_packer_if;
  import locn_pkg::*;

  logic       UART_TX_FLAG;
  locn_word_t LOCN_X;
  locn_word_t LOCN_Y;
  locn_word_t LOCN_DMIN;
  logic       TX_SERIAL;
  logic       TX_BUSY;
  logic       FRAME_DONE;
  logic [7:0] DROP_CNT;

  modport master (
    output UART_TX_FLAG, LOCN_X, LOCN_Y, LOCN_DMIN,
    input  TX_SERIAL, TX_BUSY, FRAME_DONE, DROP_CNT
  );

  modport slave (
    input  UART_TX_FLAG, LOCN_X, LOCN_Y, LOCN_DMIN,
    output TX_SERIAL, TX_BUSY, FRAME_DONE, DROP_CNT
  );
endinterface

// File: rtl/locn_tx_packer_uart_tx.sv
// locn_uart_tx: 8N1 byte serialiser. byte_ready is high while idle and in the
// last cycle of the stop bit, so back-to-back bytes leave no idle gap.
module locn_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_sh;    // bit 0 drives the line; refills with ones (idle/stop)
  logic          w_bit_end;
  logic          w_last;

  assign w_bit_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last     = r_busy & w_bit_end & (r_bit == 4'd9);
  assign byte_ready = ~r_busy | w_last;
  assign tx         = r_sh[0];

  // Baud counter and frame shifter; a new byte may load on the final stop cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= '1;
    end else if (byte_valid && byte_ready) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= {1'b1, byte_data, 1'b0};
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        r_sh  <= {1'b1, r_sh[9:1]};
        if (r_bit == 4'd9) r_busy <= 1'b0;
        else               r_bit  <= r_bit + 4'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/locn_tx_packer.sv
// locn_tx_packer: captures solver X/Y(/Dmin) on the rising edge of UART_TX_FLAG,
// holds one result pending, and sends it as a XOR-checksummed byte frame over
// an 8N1 UART. Build option LOCN_PKT_DMIN_EN adds the Dmin word to the frame.
module locn_tx_packer
  import locn_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HDR_BYTE     = LOCN_HDR_DEFAULT
) (
  input  logic            LOCN_CLK,
  input  logic            LOCN_RST,
  locn_tx_packer_if.slave bus
);
  localparam logic [3:0] IDX_LAST = 4'(LOCN_FRAME_LEN - 1);

  logic [1:0]   r_rst_sync;
  logic         w_rst_n;
  logic         r_flag_q;
  logic         w_rise;
  logic         r_pend_v;
  locn_result_t r_pend;
  locn_result_t r_act;
  locn_state_e  r_state, w_state_nxt;
  logic [3:0]   r_idx;
  logic [7:0]   r_chk;
  logic [7:0]   r_drop;
  logic         r_rdy_q;
  logic [7:0]   w_frame_byte;
  logic [7:0]   w_byte;
  logic         w_byte_valid;
  logic         w_byte_ready;
  logic         w_done;
  logic         w_tx;

  // Reset asserts immediately, releases two clocks after LOCN_RST rises.
  always_ff @(posedge LOCN_CLK or negedge LOCN_RST) begin
    if (!LOCN_RST) r_rst_sync <= '0;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_rise = bus.UART_TX_FLAG & ~r_flag_q;

  // Pending slot: newest result wins; a rise during LOAD refills it without a drop.
  always_ff @(posedge LOCN_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_flag_q <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
      r_drop   <= '0;
    end else begin
      r_flag_q <= bus.UART_TX_FLAG;
      if (w_rise) begin
        r_pend_v <= 1'b1;
        r_pend.x <= bus.LOCN_X;
        r_pend.y <= bus.LOCN_Y;
`ifdef LOCN_PKT_DMIN_EN
        r_pend.dmin <= bus.LOCN_DMIN;
`endif
        if (r_pend_v && r_state != ST_LOAD && r_drop != 8'hFF)
          r_drop <= r_drop + 8'd1;
      end else if (r_state == ST_LOAD) begin
        r_pend_v <= 1'b0;
      end
    end
  end

`ifndef LOCN_PKT_DMIN_EN
  logic w_unused_dmin;
  assign w_unused_dmin = ^bus.LOCN_DMIN;
`endif

  // Frame byte at the current index; the last slot carries the running checksum.
  always_comb begin
    w_frame_byte = HDR_BYTE;
    if (r_idx == IDX_LAST)
      w_frame_byte = r_chk;
    else if (r_idx >= 4'd1 && r_idx <= 4'd4)
      w_frame_byte = word_byte(r_act.x, 2'(r_idx - 4'd1));
    else if (r_idx >= 4'd5 && r_idx <= 4'd8)
      w_frame_byte = word_byte(r_act.y, 2'(r_idx - 4'd5));
`ifdef LOCN_PKT_DMIN_EN
    else if (r_idx >= 4'd9 && r_idx <= 4'd12)
      w_frame_byte = word_byte(r_act.dmin, 2'(r_idx - 4'd9));
`endif
  end

  // Frame FSM state register.
  always_ff @(posedge LOCN_CLK or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and serialiser handshake. LOAD already offers the header so the
  // start bit begins two clocks after capture. Serialiser idle is the second
  // consecutive ready cycle in DRAIN (the first is the last stop-bit cycle).
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_valid = 1'b0;
    w_byte       = w_frame_byte;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_pend_v) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_byte_valid = 1'b1;
        w_byte       = HDR_BYTE;
        w_state_nxt  = ST_SEND;
      end
      ST_SEND: begin
        w_byte_valid = 1'b1;
        if (w_byte_ready && r_idx == IDX_LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_byte_ready && r_rdy_q) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Active buffer, byte index and running checksum.
  always_ff @(posedge LOCN_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_act   <= '0;
      r_idx   <= '0;
      r_chk   <= '0;
      r_rdy_q <= 1'b0;
    end else begin
      r_rdy_q <= w_byte_ready;
      if (r_state == ST_LOAD) begin
        r_act <= r_pend;
        if (w_byte_ready) begin
          r_idx <= 4'd1;
          r_chk <= HDR_BYTE;
        end else begin
          r_idx <= '0;
          r_chk <= '0;
        end
      end else if (r_state == ST_SEND && w_byte_ready) begin
        r_idx <= r_idx + 4'd1;
        r_chk <= r_chk ^ w_frame_byte;
      end
    end
  end

  locn_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (LOCN_CLK),
    .rst_n     (w_rst_n),
    .byte_data (w_byte),
    .byte_valid(w_byte_valid),
    .byte_ready(w_byte_ready),
    .tx        (w_tx)
  );

  assign bus.TX_SERIAL  = w_tx;
  assign bus.TX_BUSY    = (r_state != ST_IDLE) | r_pend_v;
  assign bus.FRAME_DONE = w_done;
  assign bus.DROP_CNT   = r_drop;
endmodule

// File: tb/tb_locn_tx_packer.sv
// tb_locn_tx_packer: directed vectors for the location result packer,
// CLKS_PER_BIT=4, frames decoded from the serial line by mid-bit sampling.
module tb_locn_tx_packer;
  import locn_pkg::*;

  localparam int CPB  = 4;
  localparam int FL   = LOCN_FRAME_LEN;
  localparam int FCYC = FL * 10 * CPB;

  logic gclk  = 1'b0;
  logic grst_n = 1'b0;

  locn_tx_packer_if bus();

  locn_tx_packer #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)) dut (
    .LOCN_CLK(gclk),
    .LOCN_RST(grst_n),
    .bus     (bus)
  );

  always #5 gclk = ~gclk;

  int cyc    = 0;
  int fd_cnt = 0;
  always @(posedge gclk) cyc <= cyc + 1;
  always @(posedge gclk) if (bus.FRAME_DONE === 1'b1) fd_cnt <= fd_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_b  [0:13];
  logic [7:0] exp_b [0:13];
  int rx_start;
  int c_edge;
  int fd_at;

  // Hand-computed checksum c is supplied by the caller.
  task automatic set_exp(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] d, input logic [7:0] c);
    logic [31:0] t;
    for (int i = 0; i < 14; i++) exp_b[i] = 8'h00;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      t = x << (8 * k); exp_b[1 + k] = t[31:24];
      t = y << (8 * k); exp_b[5 + k] = t[31:24];
`ifdef LOCN_PKT_DMIN_EN
      t = d << (8 * k); exp_b[9 + k] = t[31:24];
`else
      t = d;
`endif
    end
    exp_b[FL - 1] = c;
  endtask

  task automatic pulse(input logic [31:0] x, input logic [31:0] y, input logic [31:0] d);
    @(negedge gclk);
    bus.LOCN_X = x; bus.LOCN_Y = y; bus.LOCN_DMIN = d;
    bus.UART_TX_FLAG = 1'b1;
    @(negedge gclk);
    bus.UART_TX_FLAG = 1'b0;
    c_edge = cyc;
  endtask

  task automatic rx_frame(input int n);
    int t;
    for (int b = 0; b < n; b++) begin
      t = 0;
      @(negedge gclk);
      while (bus.TX_SERIAL !== 1'b0 && t < 4 * FCYC) begin
        @(negedge gclk);
        t++;
      end
      if (t >= 4 * FCYC) begin
        check("rx_start_timeout", 64'd1, 64'd0);
        return;
      end
      if (b == 0) rx_start = cyc;
      repeat (CPB / 2) @(negedge gclk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge gclk);
        rx_b[b][i] = bus.TX_SERIAL;
      end
      repeat (CPB) @(negedge gclk);
      check("stop_bit", bus.TX_SERIAL, 1);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < FL; i++)
      check($sformatf("%s_b%0d", tag, i), rx_b[i], exp_b[i]);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (bus.FRAME_DONE !== 1'b1 && t < 100) begin
      @(negedge gclk);
      t++;
    end
    fd_at = cyc;
    if (t >= 100) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int lows, f0, f_first, t;
    bus.UART_TX_FLAG = 1'b0;
    bus.LOCN_X = '0; bus.LOCN_Y = '0; bus.LOCN_DMIN = '0;

    // reset state
    repeat (3) @(negedge gclk);
    check("rst_tx",   bus.TX_SERIAL, 1);
    check("rst_busy", bus.TX_BUSY, 0);
    check("rst_drop", bus.DROP_CNT, 0);
    check("rst_done", bus.FRAME_DONE, 0);
    grst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge gclk);
      if (bus.TX_SERIAL !== 1'b1) lows++;
    end
    check("idle_line", lows, 0);
    check("idle_busy", bus.TX_BUSY, 0);

    // single frame: A5 00 00 00 10 FF FF FF F0 BA
    set_exp(32'h0000_0010, 32'hFFFF_FFF0, 32'h0, 8'hBA);
    f0 = fd_cnt;
    pulse(32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    check("busy_pend", bus.TX_BUSY, 1);
    rx_frame(FL);
    check_frame("single");
    check("start_lat", rx_start - c_edge, 2);
    wait_done();
    check("frame_span", fd_at - rx_start, FCYC);
    @(negedge gclk);
    check("done_width", bus.FRAME_DONE, 0);
    check("done_once", fd_cnt - f0, 1);
    check("busy_after", bus.TX_BUSY, 0);

    // back-to-back: second result arrives mid-frame
    pulse(32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    fork
      rx_frame(FL);
      begin repeat (100) @(negedge gclk); pulse(32'd1, 32'd2, 32'h0); end
    join
    check_frame("b2b_first");
    wait_done();
    f_first = fd_at;
    set_exp(32'd1, 32'd2, 32'h0, 8'hA6);
    rx_frame(FL);
    check_frame("b2b_second");
    // FRAME_DONE cycle, IDLE, LOAD, then the start bit
    check("b2b_gap", rx_start - f_first, 3);
    wait_done();
    check("b2b_drop", bus.DROP_CNT, 0);

    // overrun: frame-start flag plus two more during the frame
    pulse(32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    fork
      rx_frame(FL);
      begin
        repeat (60) @(negedge gclk); pulse(32'd3, 32'd4, 32'h0);
        repeat (10) @(negedge gclk); pulse(32'd7, 32'd8, 32'h0);
      end
    join
    check("ovr_drop1", bus.DROP_CNT, 1);
    wait_done();
    set_exp(32'd7, 32'd8, 32'h0, 8'hAA);  // A5^07^08
    rx_frame(FL);
    check_frame("ovr");
    wait_done();
    for (int i = 0; i < 300; i++) pulse(i, i, 32'h0);
    check("ovr_sat", bus.DROP_CNT, 8'hFF);
    t = 0;
    while (bus.TX_BUSY !== 1'b0 && t < 3 * FCYC) begin
      @(negedge gclk);
      t++;
    end
    check("drain_idle", bus.TX_BUSY, 0);

    // reset during the start bit of byte 4
    pulse(32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    t = 0;
    while (bus.TX_SERIAL !== 1'b0 && t < 50) begin
      @(negedge gclk);
      t++;
    end
    repeat (4 * 10 * CPB + 1) @(negedge gclk);
    check("b4_start_low", bus.TX_SERIAL, 0);
    #1 grst_n = 1'b0;
    #1 check("rst_async_tx", bus.TX_SERIAL, 1);
    f0 = fd_cnt;
    repeat (5) @(negedge gclk);
    check("rst_mid_busy", bus.TX_BUSY, 0);
    check("rst_mid_drop", bus.DROP_CNT, 0);
    grst_n = 1'b1;
    repeat (50) @(negedge gclk);
    check("rst_no_done", fd_cnt - f0, 0);
    set_exp(32'd1, 32'd2, 32'h0, 8'hA6);
    pulse(32'd1, 32'd2, 32'h0);
    rx_frame(FL);
    check_frame("post_rst");
    wait_done();

`ifdef LOCN_PKT_DMIN_EN
    // Dmin frame: A5, 00 x8, 12 34 56 78, chk A5^12^34^56^78 = AD
    set_exp(32'h0, 32'h0, 32'h1234_5678, 8'hAD);
    pulse(32'h0, 32'h0, 32'h1234_5678);
    rx_frame(FL);
    check_frame("dmin");
    wait_done();
    check("dmin_span", fd_at - rx_start, 560);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
